// File: rtl/handshake_constant_match_pkg.sv
`default_nettype none
// ============================================================================
// Module      : handshake_constant_match_pkg
// Description : Shared slot-state encodings and saturating-increment helper
//               for the handshake buffers.
// Revision    : 1.0 - initial release
// ============================================================================
package handshake_constant_match_pkg;

    // Slot occupancy encoded as {main_v, skid_v}; 2'b01 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_TWO   = 2'b11;

    typedef enum logic [1:0] {
        SLOT_EMPTY = ST_EMPTY,
        SLOT_ONE   = ST_ONE,
        SLOT_TWO   = ST_TWO
    } slot_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_constant_match_if.sv
`default_nettype none
// ============================================================================
// Module      : handshake_constant_match_if
// Description : Token-in / match-out handshake bundle with debug counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface handshake_constant_match_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic                  outs;
    logic                  outs_valid;
    logic                  outs_ready;
    logic [CNT_WIDTH-1:0]  mismatch_count;

    // Environment side: produces tokens, consumes results.
    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid, mismatch_count
    );

    // Block side.
    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid, mismatch_count
    );
endinterface
`default_nettype wire

// File: rtl/handshake_skid_buffer_1b.sv
`default_nettype none
// ============================================================================
// Module      : handshake_skid_buffer_1b
// Description : Two-slot registered skid buffer; full throughput with the
//               upstream ready driven straight from a state flop.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_skid_buffer_1b
    import handshake_constant_match_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_valid,
    output logic                  o_ready,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_valid,
    input  wire logic             i_ready
);

    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_main_d;
    logic [WIDTH-1:0] r_skid_d;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;

    assign o_valid    = r_state[1];
    assign o_ready    = ~r_state[0];
    assign o_data     = r_main_d;
    assign w_in_xfer  = i_valid & ~r_state[0];
    assign w_out_xfer = i_ready & r_state[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SLOT_EMPTY;
            r_main_d <= '0;
            r_skid_d <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_main_d <= w_main_nxt;
            r_skid_d <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main_d;
        w_skid_nxt  = r_skid_d;
        case (r_state)
            SLOT_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = SLOT_ONE;
                    w_main_nxt  = i_data;
                end
            end
            SLOT_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_nxt = i_data;
                end else if (w_in_xfer) begin
                    w_state_nxt = SLOT_TWO;
                    w_skid_nxt  = i_data;
                end else if (w_out_xfer) begin
                    w_state_nxt = SLOT_EMPTY;
                end
            end
            SLOT_TWO: begin
                // Ready is low here, so only the drain path can fire.
                if (w_out_xfer) begin
                    w_state_nxt = SLOT_ONE;
                    w_main_nxt  = r_skid_d;
                end
            end
            default: begin
                w_state_nxt = SLOT_EMPTY;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/handshake_constant_match.sv
`default_nettype none
// ============================================================================
// Module      : handshake_constant_match
// Description : Compares each accepted token with a constant, streams a 1-bit
//               match result and keeps a saturating mismatch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_constant_match
    import handshake_constant_match_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] EXPECTED   = 32'h07D2_0607,
    parameter int          CNT_WIDTH  = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    handshake_constant_match_if.slave bus
);

    localparam logic [DATA_WIDTH-1:0] c_expected = DATA_WIDTH'(EXPECTED);
    localparam logic [31:0]           c_cnt_max  = 32'((64'd1 << CNT_WIDTH) - 64'd1);

    logic                 w_match;
    logic                 w_in_xfer;
    logic [CNT_WIDTH-1:0] r_mismatch_count;

    assign w_match            = (bus.ins == c_expected);
    assign w_in_xfer          = bus.ins_valid & bus.ins_ready;
    assign bus.mismatch_count = r_mismatch_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch_count <= '0;
        end else if (w_in_xfer && !w_match) begin
            r_mismatch_count <= CNT_WIDTH'(sat_inc(32'(r_mismatch_count), c_cnt_max));
        end
    end

    handshake_skid_buffer_1b #(
        .WIDTH (1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_match),
        .i_valid (bus.ins_valid),
        .o_ready (bus.ins_ready),
        .o_data  (bus.outs),
        .o_valid (bus.outs_valid),
        .i_ready (bus.outs_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_handshake_constant_match.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_constant_match
// Description : Two DUT variants (32b/8b counter and 27b/2b counter) driven
//               in lockstep and compared against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_constant_match;

    localparam logic [31:0] c_exp_a = 32'h07D2_0607;
    localparam logic [26:0] c_exp_b = 27'h7D20607;

    logic        clk;
    logic        rst;
    logic [31:0] d_ins;
    logic        d_valid;
    logic        d_ready;
    logic        chk_en;

    int n_tests;
    int n_fail;

    handshake_constant_match_if #(.DATA_WIDTH(32), .CNT_WIDTH(8)) ifa ();
    handshake_constant_match_if #(.DATA_WIDTH(27), .CNT_WIDTH(2)) ifb ();

    assign ifa.ins        = d_ins;
    assign ifa.ins_valid  = d_valid;
    assign ifa.outs_ready = d_ready;
    assign ifb.ins        = d_ins[26:0];
    assign ifb.ins_valid  = d_valid;
    assign ifb.outs_ready = d_ready;

    handshake_constant_match #(
        .DATA_WIDTH (32),
        .EXPECTED   (32'h07D2_0607),
        .CNT_WIDTH  (8)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    handshake_constant_match #(
        .DATA_WIDTH (27),
        .EXPECTED   (32'h07D2_0607),
        .CNT_WIDTH  (2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: an ordered result queue of depth two per DUT.
    bit qa[$];
    bit qb[$];
    bit log_a[$];
    int cnta;
    int cntb;

    always @(posedge clk) begin
        bit in_x;
        bit out_x;
        bit ma;
        bit mb;
        if (rst) begin
            qa.delete();
            qb.delete();
            log_a.delete();
            cnta = 0;
            cntb = 0;
        end else begin
            in_x  = d_valid && (qa.size() < 2);
            out_x = d_ready && (qa.size() > 0);
            ma    = (d_ins == c_exp_a);
            mb    = (d_ins[26:0] == c_exp_b);
            if (out_x) begin
                log_a.push_back(qa.pop_front());
                void'(qb.pop_front());
            end
            if (in_x) begin
                qa.push_back(ma);
                qb.push_back(mb);
                if (!ma && cnta < 255) cnta++;
                if (!mb && cntb < 3)   cntb++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_outs_valid", 32'(ifa.outs_valid), 32'(qa.size() > 0));
            check("a_ins_ready",  32'(ifa.ins_ready),  32'(qa.size() < 2));
            check("a_count",      32'(ifa.mismatch_count), 32'(cnta));
            check("b_outs_valid", 32'(ifb.outs_valid), 32'(qb.size() > 0));
            check("b_ins_ready",  32'(ifb.ins_ready),  32'(qb.size() < 2));
            check("b_count",      32'(ifb.mismatch_count), 32'(cntb));
            if (qa.size() > 0) check("a_outs", 32'(ifa.outs), 32'(qa[0]));
            if (qb.size() > 0) check("b_outs", 32'(ifb.outs), 32'(qb[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit accepted;
        int exp5[5];
        exp5 = '{1, 2, 3, 3, 3};
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rst     = 1'b1;
        d_ins   = '0;
        d_valid = 1'b0;
        d_ready = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        tick();
        tick();
        check("t1_a_valid", 32'(ifa.outs_valid), 0);
        check("t1_a_outs",  32'(ifa.outs), 0);
        check("t1_a_ready", 32'(ifa.ins_ready), 1);
        check("t1_a_count", 32'(ifa.mismatch_count), 0);
        check("t1_b_valid", 32'(ifb.outs_valid), 0);
        check("t1_b_outs",  32'(ifb.outs), 0);
        check("t1_b_ready", 32'(ifb.ins_ready), 1);
        check("t1_b_count", 32'(ifb.mismatch_count), 0);

        // Single matching token, one-cycle latency
        d_ins   = c_exp_a;
        d_valid = 1'b1;
        d_ready = 1'b1;
        tick();
        d_valid = 1'b0;
        check("t2_a_valid", 32'(ifa.outs_valid), 1);
        check("t2_a_outs",  32'(ifa.outs), 1);
        check("t2_b_valid", 32'(ifb.outs_valid), 1);
        check("t2_b_outs",  32'(ifb.outs), 1);
        check("t2_b_count", 32'(ifb.mismatch_count), 0);
        tick();
        check("t2_drained", 32'(ifa.outs_valid), 0);

        // Eight back-to-back alternating tokens
        log_a.delete();
        for (int i = 0; i < 8; i++) begin
            d_ins   = (i % 2 == 0) ? c_exp_a : (c_exp_a ^ 32'h1);
            d_valid = 1'b1;
            tick();
        end
        d_valid = 1'b0;
        tick();
        tick();
        check("t3_n_results", 32'(log_a.size()), 8);
        for (int i = 0; i < 8 && i < log_a.size(); i++)
            check("t3_result", 32'(log_a[i]), 32'(i % 2 == 0));
        check("t3_a_count", 32'(ifa.mismatch_count), 4);
        check("t3_b_count", 32'(ifb.mismatch_count), 3);

        // Backpressure: fill both slots, hold a third token upstream
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        d_ready = 1'b0;
        d_valid = 1'b1;
        d_ins   = c_exp_a ^ 32'h10;
        tick();
        d_ins = c_exp_a;
        tick();
        check("t4_ready_low", 32'(ifa.ins_ready), 0);
        d_ins = c_exp_a ^ 32'h100;
        tick();
        tick();
        check("t4_held_ready", 32'(ifa.ins_ready), 0);
        check("t4_held_count", 32'(ifa.mismatch_count), 1);
        check("t4_held_valid", 32'(ifa.outs_valid), 1);
        check("t4_held_outs",  32'(ifa.outs), 0);
        d_ready  = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 8 && !accepted; k++) begin
            if (ifa.ins_ready) accepted = 1'b1;
            tick();
        end
        d_valid = 1'b0;
        check("t4_accept_in_time", 32'(accepted), 1);
        tick();
        tick();
        tick();
        check("t4_n_results", 32'(log_a.size()), 3);
        if (log_a.size() == 3) begin
            check("t4_res0", 32'(log_a[0]), 0);
            check("t4_res1", 32'(log_a[1]), 1);
            check("t4_res2", 32'(log_a[2]), 0);
        end
        check("t4_a_count", 32'(ifa.mismatch_count), 2);
        check("t4_b_count", 32'(ifb.mismatch_count), 2);

        // Narrow counter saturation
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        d_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_ins   = c_exp_a ^ 32'h1;
            d_valid = 1'b1;
            tick();
            check("t5_b_count", 32'(ifb.mismatch_count), 32'(exp5[i]));
        end
        d_valid = 1'b0;
        tick();

        // Reset while full with a pending token
        d_ready = 1'b0;
        d_valid = 1'b1;
        d_ins   = c_exp_a;
        tick();
        d_ins = c_exp_a ^ 32'h1;
        tick();
        check("t6_full_ready", 32'(ifa.ins_ready), 0);
        d_ins   = c_exp_a;
        d_ready = 1'b1;
        rst     = 1'b1;
        tick();
        check("t6_a_valid", 32'(ifa.outs_valid), 0);
        check("t6_a_outs",  32'(ifa.outs), 0);
        check("t6_a_ready", 32'(ifa.ins_ready), 1);
        check("t6_a_count", 32'(ifa.mismatch_count), 0);
        check("t6_b_count", 32'(ifb.mismatch_count), 0);
        rst     = 1'b0;
        d_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_stale", 32'(ifa.outs_valid), 0);
        end

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            d_valid = ($urandom_range(0, 3) != 0);
            d_ready = ($urandom_range(0, 3) != 0);
            sel     = int'($urandom_range(0, 3));
            case (sel)
                0, 1:    d_ins = c_exp_a;
                2:       d_ins = c_exp_a ^ (32'h1 << $urandom_range(0, 31));
                default: d_ins = $urandom;
            endcase
            tick();
        end
        d_valid = 1'b0;
        d_ready = 1'b1;
        tick();
        tick();
        tick();
        check("end_drained", 32'(ifa.outs_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
